// File: rtl/p_s_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// Imported by the bit counter and the top.
package p_s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int C_BITS_DEFAULT = 255;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p_s_bit_counter.sv
// Loadable down-counter tracking the index of the bit on Q.
// Saturates at zero and exposes a zero flag.
module p_s_bit_counter
  import p_s_pkg::*;
#(
  parameter int C_BITS_IN = C_BITS_DEFAULT,
  parameter int CW = cnt_width(C_BITS_IN)
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  localparam logic [CW-1:0] LAST = CW'(C_BITS_IN - 1);

  always_ff @(posedge CK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAST;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/p_s_converter.sv
// Parallel-to-serial converter, MSB first, valid/ready input side.
// Back-to-back words stream with no idle bit in between.
module p_s_converter
  import p_s_pkg::*;
#(
  parameter int C_BITS_IN = C_BITS_DEFAULT
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 LOAD,
  input  logic [C_BITS_IN-1:0] D,
  output logic                 READY,
  output logic                 Q,
  output logic                 VALID,
  output logic                 SOF
);

  localparam int CW = cnt_width(C_BITS_IN);

  state_t               state;
  logic [C_BITS_IN-1:0] sr;
  logic [CW-1:0]        cnt;
  logic                 zero;
  logic                 accept;

  assign READY  = !RST && (state == IDLE || zero);
  assign accept = LOAD && READY;

  p_s_bit_counter #(
    .C_BITS_IN(C_BITS_IN),
    .CW       (CW)
  ) u_cnt (
    .CK  (CK),
    .RST (RST),
    .load(accept),
    .dec (state == SHIFT),
    .cnt (cnt),
    .zero(zero)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      sr    <= '0;
      Q     <= 1'b0;
      VALID <= 1'b0;
      SOF   <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= D;
      Q     <= D[C_BITS_IN-1];
      VALID <= 1'b1;
      SOF   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          Q     <= 1'b0;
          VALID <= 1'b0;
          SOF   <= 1'b0;
        end
        SHIFT: begin
          SOF <= 1'b0;
          if (cnt != '0) begin
            sr <= sr << 1;
            Q  <= sr[C_BITS_IN-2];
          end else begin
            // last bit sent and nothing queued behind it
            state <= IDLE;
            Q     <= 1'b0;
            VALID <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p_s_converter.sv
// Directed vector table plus a random loopback run for p_s_converter.
// Expected values are hand-derived; the loopback uses a local deserializer.
module tb_p_s_converter;

  localparam int W = 8;

  logic         CK = 1'b0;
  logic         RST = 1'b1;
  logic         LOAD = 1'b0;
  logic [W-1:0] D = '0;
  logic         READY, Q, VALID, SOF;

  int total = 0;
  int bad = 0;

  p_s_converter #(.C_BITS_IN(W)) dut (
    .CK   (CK),
    .RST  (RST),
    .LOAD (LOAD),
    .D    (D),
    .READY(READY),
    .Q    (Q),
    .VALID(VALID),
    .SOF  (SOF)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic         rst;
    logic         load;
    logic [W-1:0] d;
    logic         q;
    logic         valid;
    logic         sof;
    logic         ready;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic load,
                     input logic [W-1:0] d, input logic q,
                     input logic valid, input logic sof,
                     input logic ready);
    vec_t v;
    v.rst = rst; v.load = load; v.d = d;
    v.q = q; v.valid = valid; v.sof = sof; v.ready = ready;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%b want=%b", name, idx, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // serial bits of a word, MSB first
  task automatic add_word_tail(input logic [W-1:0] w);
    for (int i = W - 2; i >= 0; i--)
      add(0, 0, 8'h5A, w[i], 1, 0, (i == 0));
  endtask

  logic [W-1:0] sent[$];
  logic [W-1:0] rcvd[$];
  logic [W-1:0] acc_w;
  int           bcnt;
  int           k;
  int           cyc;
  logic         acc;

  initial begin
    // reset, with a word offered on the reset edge
    add(1, 1, 8'hFF, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // single word 0xA5
    add(0, 1, 8'hA5, 1, 1, 1, 0);
    add(0, 0, 8'h33, 0, 1, 0, 0);
    add(0, 0, 8'hCC, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'hFF, 0, 1, 0, 0);
    add(0, 0, 8'h12, 1, 1, 0, 0);
    add(0, 0, 8'h34, 0, 1, 0, 0);
    add(0, 0, 8'h56, 1, 1, 0, 1);
    add(0, 0, 8'hFF, 0, 0, 0, 1);
    // back-to-back 0xFF then 0x0F
    add(0, 1, 8'hFF, 1, 1, 1, 0);
    for (int i = 6; i >= 0; i--)
      add(0, 1, 8'hFF, 1, 1, 0, (i == 0));
    add(0, 1, 8'h0F, 0, 1, 1, 0);
    add_word_tail(8'h0F);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // busy LOAD with 0x7E must be ignored
    add(0, 1, 8'h81, 1, 1, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 1, 8'h7E, 0, 1, 0, 0);
    add(0, 0, 8'h7E, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // reset mid-word, then 0x3C
    add(0, 1, 8'hC3, 1, 1, 1, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 0);
    add(1, 1, 8'hFF, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    add(0, 1, 8'h3C, 0, 1, 1, 0);
    add_word_tail(8'h3C);
    add(0, 0, 8'h00, 0, 0, 0, 1);

    foreach (tv[i]) begin
      RST  = tv[i].rst;
      LOAD = tv[i].load;
      D    = tv[i].d;
      tick();
      chk("q", i, Q, tv[i].q);
      chk("valid", i, VALID, tv[i].valid);
      chk("sof", i, SOF, tv[i].sof);
      chk("ready", i, READY, tv[i].ready);
    end

    // loopback: 64 random words through a local deserializer
    RST  = 1'b0;
    LOAD = 1'b0;
    for (int i = 0; i < 64; i++) sent.push_back(W'($urandom));
    k    = 0;
    bcnt = 0;
    cyc  = 0;
    D    = sent[0];
    while (cyc < 3000 && (k < 64 || VALID)) begin
      LOAD = (k < 64) && ($urandom_range(0, 7) != 0);
      if (k < 64) D = sent[k];
      #1;
      acc = LOAD && READY;
      tick();
      cyc++;
      if (acc) k++;
      if (VALID) begin
        if (SOF) begin
          acc_w = {{(W-1){1'b0}}, Q};
          bcnt  = 1;
        end else begin
          acc_w = {acc_w[W-2:0], Q};
          bcnt++;
        end
        if (bcnt == W) rcvd.push_back(acc_w);
      end
    end
    LOAD = 1'b0;
    total++;
    if (cyc >= 3000) begin
      bad++;
      $display("FAIL loop_timeout got=%0d want=<3000", cyc);
    end
    total++;
    if (rcvd.size() != 64) begin
      bad++;
      $display("FAIL loop_count got=%0d want=64", rcvd.size());
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (i >= rcvd.size() || rcvd[i] !== sent[i]) begin
        bad++;
        $display("FAIL loop_word%0d got=%h want=%h", i,
                 (i < rcvd.size()) ? rcvd[i] : 8'hxx, sent[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
